index_to_mask_builder: RTL
==========================

// Module: index_to_mask_builder
// PURPOSE
//  Inverse of the first-one priority encoder: collects a stream of bit indices and
//  decodes each into a one-hot bit, ORing them into a VECTOR_LENGTH-wide mask.
//  The finished mask, with a population count, goes downstream under valid/ready.
//  Sits between index producers (free-slot / wakeup / register-list logic) and
//  mask consumers (scoreboards, issue-queue ready vectors).
// PARAMETERS
//  VECTOR_LENGTH  32  width of the assembled mask, 2..32
//  INDEX_WIDTH    5   width of index_in; must equal clog2(VECTOR_LENGTH) (min 1)
// PORTS
//  clk_in            input   1                  clock, all logic on rising edge
//  reset_n_in        input   1                  synchronous reset, active-low
//  index_valid_in    input   1                  index_in / index_last_in valid
//  index_in          input   INDEX_WIDTH        bit position to set
//  index_last_in     input   1                  final index of the current mask
//  index_ready_out   output  1                  builder accepts an index this cycle
//  mask_valid_out    output  1                  mask_out / count / error valid
//  mask_out          output  VECTOR_LENGTH      assembled mask
//  mask_count_out    output  INDEX_WIDTH+1      number of distinct set bits in mask_out
//  mask_error_out    output  1                  >=1 out-of-range index was dropped
//  mask_ready_in     input   1                  downstream accepts the mask
// BEHAVIOUR
//  Reset (reset_n_in==0 at a clock edge), from any state, mid-mask included:
//   - state = COLLECT, accumulated mask and count = 0, error = 0.
//   - index_ready_out = 1, mask_valid_out = 0, mask_out = 0, mask_count_out = 0,
//     mask_error_out = 0.
//   - A partially built mask is discarded; nothing is emitted for it.
//  Index accept: index_valid_in & index_ready_out at a clock edge.
//  State COLLECT (index_ready_out=1, mask_valid_out=0):
//   - In range (index_in < VECTOR_LENGTH): set that mask bit.
//   - Count increments only if that bit was previously clear; duplicates are idempotent.
//   - Out of range (index_in >= VECTOR_LENGTH): mask and count unchanged;
//     the sticky error flag is set.
//   - Accept with index_last_in=1: the index is applied as above, then the state
//     moves to PRESENT.
//   - mask_valid_out rises on the cycle after the last index is accepted (1-cycle
//     latency), carrying that index's contribution.
//  State PRESENT (index_ready_out=0, mask_valid_out=1):
//   - mask_out, mask_count_out and mask_error_out are held stable while
//     mask_ready_in=0. index_valid_in is ignored; no index is consumed.
//   - Handshake when mask_ready_in=1 at a clock edge:
//       accumulator, count and error clear to 0; state returns to COLLECT.
//       Next cycle: index_ready_out=1 and mask_valid_out=0 (one bubble; no
//       same-cycle bypass).
//  Outputs are registered; no combinational path from any input to any output.
//  mask_out, mask_count_out and mask_error_out read 0 whenever mask_valid_out=0.
//  Count width rules:
//   - count <= VECTOR_LENGTH always; INDEX_WIDTH+1 bits hold the full-mask value.
//   - A full mask with VECTOR_LENGTH=32 yields count = 32 (6'b100000).
//  Empty-mask case: a lone index that is out of range with last=1 yields
//   mask_valid_out=1, mask_out=0, count=0, error=1.
//  There is no empty-without-index emission; a mask always needs >=1 accepted index.
//  Wrap-around: after PRESENT->COLLECT the next mask starts from zero; there is
//   no carry-over of bits or error between masks.
// TESTING
//  T1 reset: hold reset_n_in=0 3 cycles, drive index_valid_in=1 -> ready=1, mask_valid=0,
//     mask_out=0, count=0, error=0; no state change.
//  T2 basic: indices 3,0,31 (last on 31) back-to-back, mask_ready_in=1 -> mask_valid for one
//     cycle with mask=32'h8000_0009, count=3, error=0; ready=0 that cycle only.
//  T3 dup/backpressure: indices 5,5,5(last), mask_ready_in=0 for 4 cycles -> mask=32'h20,
//     count=1 held stable 4 cycles, index_valid_in ignored; released on mask_ready_in=1.
//  T4 range: VECTOR_LENGTH=24, INDEX_WIDTH=5; indices 23, 30(last) -> mask=24'h80_0000,
//     count=1, error=1; the next mask (index 0, last) -> mask=1, error=0.
//  T5 full: VECTOR_LENGTH=32, indices 0..31 (last on 31) -> mask=32'hFFFF_FFFF, count=6'd32.
//  T6 reset mid-op: accept 7, 9, assert reset 1 cycle, then 2(last) -> mask=32'h4, count=1.

Source files
------------

// File: rtl/index_to_mask_builder.sv
// Collects a stream of bit indices into a one-hot-ORed mask with a distinct-bit
// population count, then presents the finished mask downstream under valid/ready.
module index_to_mask_builder #(
  parameter int VECTOR_LENGTH = 32,
  parameter int INDEX_WIDTH   = 5
) (
  input  logic                     clk_in,
  input  logic                     reset_n_in,
  input  logic                     index_valid_in,
  input  logic [INDEX_WIDTH-1:0]   index_in,
  input  logic                     index_last_in,
  output logic                     index_ready_out,
  output logic                     mask_valid_out,
  output logic [VECTOR_LENGTH-1:0] mask_out,
  output logic [INDEX_WIDTH:0]     mask_count_out,
  output logic                     mask_error_out,
  input  logic                     mask_ready_in
);

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    PRESENT = 1'b1
  } state_e;

  localparam int CW = INDEX_WIDTH + 1;
  localparam logic [CW-1:0] VL = CW'(VECTOR_LENGTH);

  state_e                   state_q, state_d;
  logic [VECTOR_LENGTH-1:0] acc_q, acc_d;
  logic [CW-1:0]            count_q, count_d;
  logic                     err_q, err_d;

  logic                     in_range;
  logic [VECTOR_LENGTH-1:0] onehot;
  logic                     bit_is_new;

  assign in_range   = {1'b0, index_in} < VL;
  assign onehot     = in_range ? (VECTOR_LENGTH'(1) << index_in) : '0;
  assign bit_is_new = in_range && ((acc_q & onehot) == '0);

  // NOTE: every always_comb target gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    err_d   = err_q;
    unique case (state_q)
      COLLECT: begin
        if (index_valid_in) begin
          if (in_range) begin
            acc_d = acc_q | onehot;
            if (bit_is_new) count_d = count_q + CW'(1);
          end else begin
            err_d = 1'b1;
          end
          if (index_last_in) state_d = PRESENT;
        end
      end
      PRESENT: begin
        // Handshake frees the accumulator; the next mask starts from zero.
        if (mask_ready_in) begin
          state_d = COLLECT;
          acc_d   = '0;
          count_d = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from values sampled at the same edge.
  always_ff @(posedge clk_in) begin
    if (!reset_n_in) begin
      state_q <= COLLECT;
      acc_q   <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Outputs depend only on registers; payload reads zero while not valid.
  assign index_ready_out = (state_q == COLLECT);
  assign mask_valid_out  = (state_q == PRESENT);
  assign mask_out        = mask_valid_out ? acc_q   : '0;
  assign mask_count_out  = mask_valid_out ? count_q : '0;
  assign mask_error_out  = mask_valid_out & err_q;

endmodule
